// File: rtl/prv664_btb_pkg.sv
`default_nettype none
// ============================================================================
// Module : prv664_btb_pkg
// Brief  : Shared types and constants for the set-associative BTB.
// Rev    : 1.0  initial release
// ============================================================================
package prv664_btb_pkg;

  localparam int c_XLEN   = 32;
  localparam int c_GO_LSB = 2;
  localparam int c_GO_W   = 2;
  localparam int c_IDX_LSB = c_GO_LSB + c_GO_W;

  localparam logic [2:0] c_BT_NONE = 3'd0;
  localparam logic [2:0] c_BT_COND = 3'd1;
  localparam logic [2:0] c_BT_JAL  = 3'd2;
  localparam logic [2:0] c_BT_JALR = 3'd3;
  localparam logic [2:0] c_BT_CALL = 3'd4;
  localparam logic [2:0] c_BT_RET  = 3'd5;

  // Stored tags are zero-extended to XLEN so the entry layout is independent
  // of the TAG_LEN parameter of the instantiating module.
  typedef struct packed {
    logic              valid;
    logic [c_XLEN-1:0] tag;
    logic [c_GO_W-1:0] groupoffset;
    logic [2:0]        branchtype;
    logic [c_XLEN-1:0] target;
  } btb_entry_t;

  typedef enum logic [0:0] {
    FL_IDLE  = 1'b0,
    FL_FLUSH = 1'b1
  } flush_state_e;

endpackage
`default_nettype wire

// File: rtl/btb_set_way_sel.sv
`default_nettype none
// ============================================================================
// Module : btb_set_way_sel
// Brief  : Hit-way, lowest-invalid-way and victim-way selection for one set.
// Rev    : 1.0  initial release
// ============================================================================
module btb_set_way_sel
  import prv664_btb_pkg::*;
#(
  parameter  int WAYS = 2,
  localparam int c_WW = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]   valid_i,
  input  logic [c_XLEN-1:0] tags_i [WAYS],
  input  logic [c_XLEN-1:0] tag_i,
  input  logic [c_WW-1:0]   victim_i,
  output logic              hit_o,
  output logic [c_WW-1:0]   hit_way_o,
  output logic [c_WW-1:0]   fill_way_o,
  output logic              advance_o
);

  logic            w_has_inv;
  logic [c_WW-1:0] w_inv_way;

  // Descending scan so the lowest matching way is the last one assigned.
  always_comb begin
    hit_o     = 1'b0;
    hit_way_o = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_i[w] && (tags_i[w] == tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = c_WW'(w);
      end
      if (!valid_i[w]) begin
        w_has_inv = 1'b1;
        w_inv_way = c_WW'(w);
      end
    end
  end

  assign fill_way_o = hit_o ? hit_way_o : (w_has_inv ? w_inv_way : victim_i);
  assign advance_o  = !hit_o && !w_has_inv;

endmodule
`default_nettype wire

// File: rtl/btb_assoc.sv
`default_nettype none
// ============================================================================
// Module : btb_assoc
// Brief  : N-way set-associative BTB, 1-cycle registered lookup, round-robin
//          replacement and a SETS-cycle flush sweep. Optional same-cycle
//          write-to-read bypass enabled by macro BTB_WR_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module btb_assoc
  import prv664_btb_pkg::*;
#(
  parameter int SETS    = 16,
  parameter int WAYS    = 2,
  parameter int TAG_LEN = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              btb_rd_req_i,
  input  logic [c_XLEN-1:0] btb_rd_pc_i,
  output logic              btb_rd_valid_o,
  output logic              btb_rd_hit_o,
  output logic [c_XLEN-1:0] btb_rd_predictedpc_o,
  output logic [1:0]        btb_rd_groupoffset_o,
  output logic [2:0]        btb_rd_branchtype_o,
  input  logic              btb_wr_req_i,
  input  logic [c_XLEN-1:0] btb_wr_pc_i,
  input  logic [c_XLEN-1:0] btb_wr_predictedpc_i,
  input  logic [2:0]        btb_wr_branchtype_i,
  input  logic              btb_flush_i,
  output logic              btb_busy_o
);

  localparam int c_IW      = $clog2(SETS);
  localparam int c_WW      = $clog2(WAYS);
  localparam int c_TAG_LSB = c_IDX_LSB + c_IW;

  btb_entry_t      mem_q    [SETS][WAYS];
  logic [c_WW-1:0] victim_q [SETS];

  flush_state_e    state_q, state_d;
  logic [c_IW-1:0] cnt_q, cnt_d;
  logic            w_busy;

  logic              rd_valid_q;
  logic              rd_hit_q, rd_hit_d;
  logic [c_XLEN-1:0] rd_target_q, rd_target_d;
  logic [c_GO_W-1:0] rd_go_q, rd_go_d;
  logic [2:0]        rd_type_q, rd_type_d;

  // Address decomposition
  logic [c_IW-1:0]   w_rd_idx, w_wr_idx;
  logic [c_XLEN-1:0] w_rd_tag, w_wr_tag;

  assign w_rd_idx = btb_rd_pc_i[c_IDX_LSB +: c_IW];
  assign w_wr_idx = btb_wr_pc_i[c_IDX_LSB +: c_IW];
  assign w_rd_tag = c_XLEN'(btb_rd_pc_i[c_TAG_LSB +: TAG_LEN]);
  assign w_wr_tag = c_XLEN'(btb_wr_pc_i[c_TAG_LSB +: TAG_LEN]);

  logic [WAYS-1:0]   w_rd_valid, w_wr_valid;
  logic [c_XLEN-1:0] w_rd_tags [WAYS];
  logic [c_XLEN-1:0] w_wr_tags [WAYS];

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      w_rd_valid[w] = mem_q[w_rd_idx][w].valid;
      w_rd_tags[w]  = mem_q[w_rd_idx][w].tag;
      w_wr_valid[w] = mem_q[w_wr_idx][w].valid;
      w_wr_tags[w]  = mem_q[w_wr_idx][w].tag;
    end
  end

  logic            w_rd_hit, w_rd_unused_adv;
  logic [c_WW-1:0] w_rd_hit_way, w_rd_unused_way;
  logic            w_wr_unused_hit, w_wr_adv;
  logic [c_WW-1:0] w_wr_unused_hit_way, w_wr_way;

  btb_set_way_sel #(.WAYS(WAYS)) u_rd_sel (
    .valid_i    (w_rd_valid),
    .tags_i     (w_rd_tags),
    .tag_i      (w_rd_tag),
    .victim_i   (victim_q[w_rd_idx]),
    .hit_o      (w_rd_hit),
    .hit_way_o  (w_rd_hit_way),
    .fill_way_o (w_rd_unused_way),
    .advance_o  (w_rd_unused_adv)
  );

  btb_set_way_sel #(.WAYS(WAYS)) u_wr_sel (
    .valid_i    (w_wr_valid),
    .tags_i     (w_wr_tags),
    .tag_i      (w_wr_tag),
    .victim_i   (victim_q[w_wr_idx]),
    .hit_o      (w_wr_unused_hit),
    .hit_way_o  (w_wr_unused_hit_way),
    .fill_way_o (w_wr_way),
    .advance_o  (w_wr_adv)
  );

  // Flush sweep: the request cycle itself clears set 0, so IDLE->FLUSH loads 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_busy  = 1'b0;
    case (state_q)
      FL_IDLE: begin
        if (btb_flush_i) begin
          w_busy  = 1'b1;
          state_d = FL_FLUSH;
          cnt_d   = c_IW'(1);
        end
      end
      FL_FLUSH: begin
        w_busy = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == c_IW'(SETS - 1)) begin
          state_d = FL_IDLE;
        end
      end
      default: begin
        state_d = FL_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic       w_wr_accept;
  btb_entry_t w_wr_entry;

  assign w_wr_accept = btb_wr_req_i && !w_busy;

  always_comb begin
    w_wr_entry             = '0;
    w_wr_entry.valid       = 1'b1;
    w_wr_entry.tag         = w_wr_tag;
    w_wr_entry.groupoffset = btb_wr_pc_i[c_GO_LSB +: c_GO_W];
    w_wr_entry.branchtype  = btb_wr_branchtype_i;
    w_wr_entry.target      = btb_wr_predictedpc_i;
  end

  // Only valid bits and victim pointers are reset; payload fields are not.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        victim_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          mem_q[s][w].valid <= 1'b0;
        end
      end
    end else begin
      if (w_busy) begin
        victim_q[cnt_q] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          mem_q[cnt_q][w].valid <= 1'b0;
        end
      end
      if (w_wr_accept) begin
        mem_q[w_wr_idx][w_wr_way] <= w_wr_entry;
        if (w_wr_adv) begin
          victim_q[w_wr_idx] <= victim_q[w_wr_idx] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_hit_d    = 1'b0;
    rd_target_d = '0;
    rd_go_d     = '0;
    rd_type_d   = '0;
    if (btb_rd_req_i && w_rd_hit && !w_busy) begin
      rd_hit_d    = 1'b1;
      rd_target_d = mem_q[w_rd_idx][w_rd_hit_way].target;
      rd_go_d     = mem_q[w_rd_idx][w_rd_hit_way].groupoffset;
      rd_type_d   = mem_q[w_rd_idx][w_rd_hit_way].branchtype;
    end
`ifdef BTB_WR_BYPASS_EN
    if (btb_rd_req_i && w_wr_accept && (w_rd_idx == w_wr_idx) && (w_rd_tag == w_wr_tag)) begin
      rd_hit_d    = 1'b1;
      rd_target_d = btb_wr_predictedpc_i;
      rd_go_d     = btb_wr_pc_i[c_GO_LSB +: c_GO_W];
      rd_type_d   = btb_wr_branchtype_i;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_q  <= 1'b0;
      rd_hit_q    <= 1'b0;
      rd_target_q <= '0;
      rd_go_q     <= '0;
      rd_type_q   <= '0;
    end else begin
      rd_valid_q  <= btb_rd_req_i;
      rd_hit_q    <= rd_hit_d;
      rd_target_q <= rd_target_d;
      rd_go_q     <= rd_go_d;
      rd_type_q   <= rd_type_d;
    end
  end

  assign btb_rd_valid_o       = rd_valid_q;
  assign btb_rd_hit_o         = rd_hit_q;
  assign btb_rd_predictedpc_o = rd_target_q;
  assign btb_rd_groupoffset_o = rd_go_q;
  assign btb_rd_branchtype_o  = rd_type_q;
  assign btb_busy_o           = w_busy && !rst_i;

  // Offset and upper PC bits, and the selector outputs one side never needs.
  logic w_unused;
  assign w_unused = ^{btb_rd_pc_i, btb_wr_pc_i, w_rd_unused_way, w_rd_unused_adv,
                      w_wr_unused_hit, w_wr_unused_hit_way};

endmodule
`default_nettype wire

// File: tb/tb_btb_assoc.sv
`default_nettype none
// ============================================================================
// Module : tb_btb_assoc
// Brief  : Directed, table-driven self-checking bench for btb_assoc.
// Rev    : 1.0  initial release
// ============================================================================
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req, flush;
  logic [31:0] rd_pc, wr_pc, wr_tgt;
  logic [2:0]  wr_ty;
  logic        rd_valid, rd_hit, busy;
  logic [31:0] rd_pred;
  logic [1:0]  rd_go;
  logic [2:0]  rd_ty;

  always #5 clk = ~clk;

  btb_assoc #(.SETS(16), .WAYS(2), .TAG_LEN(20)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .btb_rd_req_i         (rd_req),
    .btb_rd_pc_i          (rd_pc),
    .btb_rd_valid_o       (rd_valid),
    .btb_rd_hit_o         (rd_hit),
    .btb_rd_predictedpc_o (rd_pred),
    .btb_rd_groupoffset_o (rd_go),
    .btb_rd_branchtype_o  (rd_ty),
    .btb_wr_req_i         (wr_req),
    .btb_wr_pc_i          (wr_pc),
    .btb_wr_predictedpc_i (wr_tgt),
    .btb_wr_branchtype_i  (wr_ty),
    .btb_flush_i          (flush),
    .btb_busy_o           (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_wr;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [2:0]  ty;
    logic        exp_hit;
    logic [31:0] exp_tgt;
    logic [1:0]  exp_go;
    logic [2:0]  exp_ty;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk_w(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] ty);
    vec_t v;
    v = '{1'b1, pc, tgt, ty, 1'b0, 32'h0, 2'd0, 3'd0};
    return v;
  endfunction

  function automatic vec_t mk_r(input logic [31:0] pc, input logic hit, input logic [31:0] tgt,
                                input logic [1:0] go, input logic [2:0] ty);
    vec_t v;
    v = '{1'b0, pc, 32'h0, 3'd0, hit, tgt, go, ty};
    return v;
  endfunction

  // All tasks are entered 1 time unit (or more) after a rising edge.
  task automatic do_write(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] ty);
    wr_req = 1'b1; wr_pc = pc; wr_tgt = tgt; wr_ty = ty;
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] pc, input logic hit,
                            input logic [31:0] tgt, input logic [1:0] go, input logic [2:0] ty);
    rd_req = 1'b1; rd_pc = pc;
    @(posedge clk); #1;
    rd_req = 1'b0;
    check({name, ".valid"}, {31'd0, rd_valid}, 32'd1);
    check({name, ".hit"},   {31'd0, rd_hit},   {31'd0, hit});
    check({name, ".tgt"},   rd_pred,           tgt);
    check({name, ".go"},    {30'd0, rd_go},    {30'd0, go});
    check({name, ".type"},  {29'd0, rd_ty},    {29'd0, ty});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Tests 1-3 and the fourth eviction write; set 1 holds tags 0x0/0x10/0x20/0x30.
    vecs[0]  = mk_w(32'h8000_0010, 32'h8000_0400, 3'd1);
    vecs[1]  = mk_r(32'h8000_0010, 1'b1, 32'h8000_0400, 2'd0, 3'd1);
    vecs[2]  = mk_w(32'h8000_004C, 32'h8000_1234, 3'd3);
    vecs[3]  = mk_r(32'h8000_004C, 1'b1, 32'h8000_1234, 2'd3, 3'd3);
    vecs[4]  = mk_r(32'h8000_0014, 1'b1, 32'h8000_0400, 2'd0, 3'd1);
    vecs[5]  = mk_r(32'h8000_0110, 1'b0, 32'h0, 2'd0, 3'd0);
    vecs[6]  = mk_w(32'h8000_1010, 32'h8000_0500, 3'd2);
    vecs[7]  = mk_w(32'h8000_2010, 32'h8000_0600, 3'd4);
    vecs[8]  = mk_r(32'h8000_0010, 1'b0, 32'h0, 2'd0, 3'd0);
    vecs[9]  = mk_r(32'h8000_1010, 1'b1, 32'h8000_0500, 2'd0, 3'd2);
    vecs[10] = mk_r(32'h8000_2010, 1'b1, 32'h8000_0600, 2'd0, 3'd4);
    vecs[11] = mk_w(32'h8000_1010, 32'h8000_0800, 3'd2);
    vecs[12] = mk_r(32'h8000_1010, 1'b1, 32'h8000_0800, 2'd0, 3'd2);
    vecs[13] = mk_r(32'h8000_2010, 1'b1, 32'h8000_0600, 2'd0, 3'd4);
    vecs[14] = mk_w(32'h8000_3010, 32'h8000_0700, 3'd5);
    vecs[15] = mk_r(32'h8000_1010, 1'b0, 32'h0, 2'd0, 3'd0);
    vecs[16] = mk_r(32'h8000_2010, 1'b1, 32'h8000_0600, 2'd0, 3'd4);
    vecs[17] = mk_r(32'h8000_3010, 1'b1, 32'h8000_0700, 2'd0, 3'd5);

    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; flush = 1'b0;
    rd_pc = '0; wr_pc = '0; wr_tgt = '0; wr_ty = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.valid", {31'd0, rd_valid}, 32'd0);
    check("reset.hit",   {31'd0, rd_hit},   32'd0);
    check("reset.tgt",   rd_pred,           32'd0);
    check("reset.busy",  {31'd0, busy},     32'd0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].is_wr)
        do_write(vecs[i].pc, vecs[i].tgt, vecs[i].ty);
      else
        read_check($sformatf("vec%0d", i), vecs[i].pc, vecs[i].exp_hit,
                   vecs[i].exp_tgt, vecs[i].exp_go, vecs[i].exp_ty);
    end

    // Flush sweep: busy for 16 cycles, mid-sweep write dropped, lookup forced to miss.
    do_write(32'h8000_0050, 32'h8000_5000, 3'd1);
    do_write(32'h8000_0060, 32'h8000_6000, 3'd1);
    do_write(32'h8000_0070, 32'h8000_7000, 3'd1);
    flush = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      if (c == 2)  flush = 1'b0;
      if (c == 10) flush = 1'b1;
      if (c == 11) flush = 1'b0;
      wr_req = (c == 5);
      wr_pc = 32'h8000_0080; wr_tgt = 32'h8000_8000; wr_ty = 3'd2;
      rd_req = (c == 3);
      rd_pc = 32'h8000_0070;
      #1;
      check($sformatf("flush.busy_c%0d", c), {31'd0, busy}, 32'd1);
      if (c == 4) begin
        check("flush.rd_valid", {31'd0, rd_valid}, 32'd1);
        check("flush.rd_hit",   {31'd0, rd_hit},   32'd0);
      end
      @(posedge clk); #1;
    end
    wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0;
    #1;
    check("flush.busy_end", {31'd0, busy}, 32'd0);
    read_check("postflush.50", 32'h8000_0050, 1'b0, 32'h0, 2'd0, 3'd0);
    read_check("postflush.70", 32'h8000_0070, 1'b0, 32'h0, 2'd0, 3'd0);
    read_check("postflush.80", 32'h8000_0080, 1'b0, 32'h0, 2'd0, 3'd0);
    read_check("postflush.2010", 32'h8000_2010, 1'b0, 32'h0, 2'd0, 3'd0);

    // Flush and write together in IDLE: flush wins.
    flush = 1'b1; wr_req = 1'b1; wr_pc = 32'h8000_00B0; wr_tgt = 32'h8000_B000; wr_ty = 3'd1;
    @(posedge clk); #1;
    flush = 1'b0; wr_req = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("flushwr.busy_end", {31'd0, busy}, 32'd0);
    read_check("flushwr.B0", 32'h8000_00B0, 1'b0, 32'h0, 2'd0, 3'd0);

    // Reset in flush cycle 7: set 9 is not yet swept, so only reset can clear it.
    do_write(32'h8000_0090, 32'h8000_9000, 3'd3);
    do_write(32'h8000_0050, 32'h8000_5000, 3'd1);
    flush = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      if (c == 2) flush = 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstflush.busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("rstflush.busy2", {31'd0, busy}, 32'd0);
    read_check("rstflush.90", 32'h8000_0090, 1'b0, 32'h0, 2'd0, 3'd0);
    read_check("rstflush.50", 32'h8000_0050, 1'b0, 32'h0, 2'd0, 3'd0);
    do_write(32'h8000_0A30, 32'h8000_A000, 3'd4);
    read_check("rstflush.A30", 32'h8000_0A30, 1'b1, 32'h8000_A000, 2'd0, 3'd4);

    // Same-cycle read and write to an empty set.
    rd_req = 1'b1; rd_pc = 32'h8000_0020;
    wr_req = 1'b1; wr_pc = 32'h8000_0020; wr_tgt = 32'h8000_0C00; wr_ty = 3'd2;
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
    check("rdwr.valid", {31'd0, rd_valid}, 32'd1);
`ifdef BTB_WR_BYPASS_EN
    check("rdwr.hit", {31'd0, rd_hit}, 32'd1);
    check("rdwr.tgt", rd_pred, 32'h8000_0C00);
    check("rdwr.type", {29'd0, rd_ty}, 32'd2);
`else
    check("rdwr.hit", {31'd0, rd_hit}, 32'd0);
    check("rdwr.tgt", rd_pred, 32'h0);
    check("rdwr.type", {29'd0, rd_ty}, 32'd0);
`endif
    read_check("rdwr.after", 32'h8000_0020, 1'b1, 32'h8000_0C00, 2'd0, 3'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
